lb_lockstep_monitor: RTL and testbench

- Downstream consumer of the two-copy Sodor5 load-buffer observation ports (lb_table valid/addr/data from core copy 1 and copy 2).
- Sequences an observation window after a start pulse and compares the two copies every cycle.
- Latches the first divergence: kind, cycle, and both addresses.
- Issues a registered verdict, so simulation benches and formal harnesses share one checker instead of ad-hoc combinational compares.

---
 rtl/lb_lockstep_monitor.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lb_lockstep_monitor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_lockstep_monitor.sv
// ---------------------------------------------------------------------------
// lb_lockstep_monitor
//
// Purpose:
//   Watches the load-buffer observation ports of two lockstep core copies.
//   A start pulse launches a run: an optional ARM delay, then a WATCH window
//   of WINDOW+1 cycles in which both copies are compared every cycle. The
//   first divergence in the run is latched (kind, WATCH index, both
//   addresses) and held until the next start or reset. Every result is a
//   flop output, so all consumers see the same registered verdict.
//
// Parameters:
//   XLEN       width of the load-buffer address/data ports
//   CNT_W      width of the WATCH index counter
//   ARM_DELAY  cycles spent in ARM before comparing (0 skips ARM)
//   WINDOW     last WATCH index compared (0 .. 2^CNT_W-2)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high; clears all state
//   start        in   single-cycle pulse; honoured in IDLE and DONE only
//   cmp_data_en  in   when 1, a data difference also counts as divergence
//   lb_valid1/2  in   copy-1 / copy-2 load-buffer entry valid
//   lb_addr1/2   in   copy-1 / copy-2 load-buffer address
//   lb_data1/2   in   copy-1 / copy-2 load-buffer data
//   busy         out  high in ARM or WATCH
//   done         out  high in DONE
//   diverge      out  sticky flag: a mismatch was seen in this run
//   div_kind     out  00 none, 01 valid, 10 addr, 11 data
//   div_cycle    out  WATCH index of the first mismatch
//   div_addr1/2  out  lb_addr1 / lb_addr2 at the first mismatch
//   watch_cnt    out  current WATCH index (holds at WINDOW in DONE)
// ---------------------------------------------------------------------------
module lb_lockstep_monitor #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 8,
  parameter int ARM_DELAY = 2,
  parameter int WINDOW    = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_data_en,
  input  logic             lb_valid1,
  input  logic [XLEN-1:0]  lb_addr1,
  input  logic [XLEN-1:0]  lb_data1,
  input  logic             lb_valid2,
  input  logic [XLEN-1:0]  lb_addr2,
  input  logic [XLEN-1:0]  lb_data2,
  output logic             busy,
  output logic             done,
  output logic             diverge,
  output logic [1:0]       div_kind,
  output logic [CNT_W-1:0] div_cycle,
  output logic [XLEN-1:0]  div_addr1,
  output logic [XLEN-1:0]  div_addr2,
  output logic [CNT_W-1:0] watch_cnt
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_VALID = 2'b01;
  localparam logic [1:0] KIND_ADDR  = 2'b10;
  localparam logic [1:0] KIND_DATA  = 2'b11;

  // The arm counter only has to reach ARM_DELAY-1, so it is sized for that
  // and never wider than one bit when ARM is absent or trivially short.
  localparam int ARM_W = (ARM_DELAY > 2) ? $clog2(ARM_DELAY) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST =
    ARM_W'((ARM_DELAY > 0) ? (ARM_DELAY - 1) : 0);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t             state_reg,     state_next;
  logic [ARM_W-1:0]   arm_cnt_reg,   arm_cnt_next;
  logic [CNT_W-1:0]   watch_cnt_reg, watch_cnt_next;
  logic               diverge_reg,   diverge_next;
  logic [1:0]         div_kind_reg,  div_kind_next;
  logic [CNT_W-1:0]   div_cycle_reg, div_cycle_next;
  logic [XLEN-1:0]    div_addr1_reg, div_addr1_next;
  logic [XLEN-1:0]    div_addr2_reg, div_addr2_next;

  // -------------------------------------------------------------------------
  // Per-cycle comparison of the two copies
  // -------------------------------------------------------------------------
  logic       both_valid;
  logic       valid_mm;
  logic       addr_mm;
  logic       data_mm;
  logic       any_mm;
  logic [1:0] mm_kind;

  // Address and data only matter when both copies hold a valid entry; two
  // invalid entries are considered equal whatever their payload.
  assign both_valid = lb_valid1 & lb_valid2;
  assign valid_mm   = lb_valid1 ^ lb_valid2;
  assign addr_mm    = both_valid & (lb_addr1 != lb_addr2);
  assign data_mm    = cmp_data_en & both_valid & (lb_data1 != lb_data2);
  assign any_mm     = valid_mm | addr_mm | data_mm;

  // Priority valid > addr > data.
  always_comb begin
    mm_kind = KIND_NONE;
    if (valid_mm) begin
      mm_kind = KIND_VALID;
    end else if (addr_mm) begin
      mm_kind = KIND_ADDR;
    end else if (data_mm) begin
      mm_kind = KIND_DATA;
    end
  end

  // -------------------------------------------------------------------------
  // Run control helpers
  // -------------------------------------------------------------------------
  logic launch;      // start honoured this cycle (IDLE or DONE only)
  logic arm_last;    // final ARM cycle
  logic watch_last;  // final WATCH cycle

  assign launch     = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
  assign arm_last   = (state_reg == ST_ARM) & (arm_cnt_reg == ARM_LAST);
  assign watch_last = (state_reg == ST_WATCH) & (watch_cnt_reg == WINDOW_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = (ARM_DELAY > 0) ? ST_ARM : ST_WATCH;
        end
      end
      ST_ARM: begin
        if (arm_last) begin
          state_next = ST_WATCH;
        end
      end
      ST_WATCH: begin
        if (watch_last) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // -------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ST_ARM:   busy = 1'b1;
      ST_WATCH: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Counter next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    arm_cnt_next   = arm_cnt_reg;
    watch_cnt_next = watch_cnt_reg;

    if (launch) begin
      arm_cnt_next   = '0;
      watch_cnt_next = '0;
    end else if (state_reg == ST_ARM) begin
      arm_cnt_next = arm_cnt_reg + 1'b1;
      if (arm_last) begin
        watch_cnt_next = '0;
      end
    end else if (state_reg == ST_WATCH) begin
      // The index stops at WINDOW so it reads as the last compared cycle
      // for as long as the run sits in DONE.
      if (!watch_last) begin
        watch_cnt_next = watch_cnt_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Divergence capture next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    diverge_next   = diverge_reg;
    div_kind_next  = div_kind_reg;
    div_cycle_next = div_cycle_reg;
    div_addr1_next = div_addr1_reg;
    div_addr2_next = div_addr2_reg;

    if (launch) begin
      diverge_next   = 1'b0;
      div_kind_next  = KIND_NONE;
      div_cycle_next = '0;
      div_addr1_next = '0;
      div_addr2_next = '0;
    end else if ((state_reg == ST_WATCH) && any_mm && !diverge_reg) begin
      // Only the first mismatch of a run is recorded; diverge_reg gates
      // every later one out.
      diverge_next   = 1'b1;
      div_kind_next  = mm_kind;
      div_cycle_next = watch_cnt_reg;
      div_addr1_next = lb_addr1;
      div_addr2_next = lb_addr2;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arm_cnt_reg   <= '0;
      watch_cnt_reg <= '0;
      diverge_reg   <= 1'b0;
      div_kind_reg  <= KIND_NONE;
      div_cycle_reg <= '0;
      div_addr1_reg <= '0;
      div_addr2_reg <= '0;
    end else begin
      arm_cnt_reg   <= arm_cnt_next;
      watch_cnt_reg <= watch_cnt_next;
      diverge_reg   <= diverge_next;
      div_kind_reg  <= div_kind_next;
      div_cycle_reg <= div_cycle_next;
      div_addr1_reg <= div_addr1_next;
      div_addr2_reg <= div_addr2_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign diverge   = diverge_reg;
  assign div_kind  = div_kind_reg;
  assign div_cycle = div_cycle_reg;
  assign div_addr1 = div_addr1_reg;
  assign div_addr2 = div_addr2_reg;
  assign watch_cnt = watch_cnt_reg;

endmodule

// File: tb/tb_lb_lockstep_monitor.sv
// ---------------------------------------------------------------------------
// tb_lb_lockstep_monitor
//
// Directed bench for lb_lockstep_monitor. Two instances: u_dut with the
// default parameters (ARM_DELAY=2, WINDOW=12) and u_dut0 with ARM_DELAY=0,
// WINDOW=0. Both share the load-buffer inputs; each has its own start.
// Inputs change 1 time unit after a rising edge, outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_lb_lockstep_monitor;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             start0;
  logic             cmp_data_en;
  logic             lb_valid1;
  logic [XLEN-1:0]  lb_addr1;
  logic [XLEN-1:0]  lb_data1;
  logic             lb_valid2;
  logic [XLEN-1:0]  lb_addr2;
  logic [XLEN-1:0]  lb_data2;

  logic             busy,      busy0;
  logic             done,      done0;
  logic             diverge,   diverge0;
  logic [1:0]       div_kind,  div_kind0;
  logic [CNT_W-1:0] div_cycle, div_cycle0;
  logic [XLEN-1:0]  div_addr1, div_addr1_0;
  logic [XLEN-1:0]  div_addr2, div_addr2_0;
  logic [CNT_W-1:0] watch_cnt, watch_cnt0;

  int total;
  int bad;

  lb_lockstep_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .ARM_DELAY(2), .WINDOW(12)
  ) u_dut (
    .clock(clk), .reset(rst), .start(start), .cmp_data_en(cmp_data_en),
    .lb_valid1(lb_valid1), .lb_addr1(lb_addr1), .lb_data1(lb_data1),
    .lb_valid2(lb_valid2), .lb_addr2(lb_addr2), .lb_data2(lb_data2),
    .busy(busy), .done(done), .diverge(diverge), .div_kind(div_kind),
    .div_cycle(div_cycle), .div_addr1(div_addr1), .div_addr2(div_addr2),
    .watch_cnt(watch_cnt)
  );

  lb_lockstep_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .ARM_DELAY(0), .WINDOW(0)
  ) u_dut0 (
    .clock(clk), .reset(rst), .start(start0), .cmp_data_en(cmp_data_en),
    .lb_valid1(lb_valid1), .lb_addr1(lb_addr1), .lb_data1(lb_data1),
    .lb_valid2(lb_valid2), .lb_addr2(lb_addr2), .lb_data2(lb_data2),
    .busy(busy0), .done(done0), .diverge(diverge0), .div_kind(div_kind0),
    .div_cycle(div_cycle0), .div_addr1(div_addr1_0), .div_addr2(div_addr2_0),
    .watch_cnt(watch_cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_same();
    lb_valid1 = 1'b1;
    lb_valid2 = 1'b1;
    lb_addr1  = 32'h64;
    lb_addr2  = 32'h64;
    lb_data1  = 32'h5;
    lb_data2  = 32'h5;
  endtask

  // Pulse start on u_dut; returns just after the edge that took it.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Start u_dut and walk through ARM; returns with WATCH index 0 current.
  task automatic go_watch();
    do_start();
    step();
    step();
  endtask

  int n;

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    start       = 1'b0;
    start0      = 1'b0;
    cmp_data_en = 1'b0;
    set_same();

    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    #1;
    chk("rst_flags", {busy, done, diverge, div_kind}, 5'b0);
    chk("rst_watch_cnt", watch_cnt, 0);
    chk("rst_div_cycle", div_cycle, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // ---------------- 1: identical streams ----------------
    set_same();
    do_start();
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk("t1_busy_cycles", n, 15);
    chk("t1_done", done, 1);
    chk("t1_diverge", diverge, 0);
    chk("t1_kind", div_kind, 2'b00);
    chk("t1_watch_hold", watch_cnt, 12);

    // ---------------- 2: valid split at 5, addr split at 8 ----------------
    go_watch();
    chk("t2_watch_idx0", watch_cnt, 0);
    for (int i = 0; i <= 12; i++) begin
      set_same();
      if (i == 5) lb_valid2 = 1'b0;
      if (i == 8) lb_addr2 = 32'h68;
      step();
      if (i == 4) chk("t2_before", diverge, 0);
      if (i == 5) chk("t2_set_next_cycle", diverge, 1);
    end
    chk("t2_done", done, 1);
    chk("t2_kind", div_kind, 2'b01);
    chk("t2_cycle", div_cycle, 5);
    chk("t2_addr2_kept", div_addr2, 32'h64);

    // ---------------- 3a: addr split at index 0, restart from DONE ----------
    set_same();
    do_start();
    chk("t3_restart_clear", {done, diverge, div_kind}, 4'b0);
    chk("t3_restart_busy", busy, 1);
    step();
    step();
    for (int i = 0; i <= 12; i++) begin
      set_same();
      if (i == 0) begin
        lb_addr1 = 32'h100;
        lb_addr2 = 32'h104;
      end
      step();
    end
    chk("t3_kind_addr", div_kind, 2'b10);
    chk("t3_addr1", div_addr1, 32'h100);
    chk("t3_addr2", div_addr2, 32'h104);
    chk("t3_cycle", div_cycle, 0);

    // ---------------- 3b: data differs, compare disabled ----------------
    set_same();
    lb_data1    = 32'h1;
    lb_data2    = 32'h2;
    cmp_data_en = 1'b0;
    go_watch();
    for (int i = 0; i <= 12; i++) step();
    chk("t3_data_off_done", done, 1);
    chk("t3_data_off_div", diverge, 0);

    // ---------------- 3c: data differs, compare enabled ----------------
    cmp_data_en = 1'b1;
    go_watch();
    for (int i = 0; i <= 12; i++) step();
    chk("t3_data_on_div", diverge, 1);
    chk("t3_data_on_kind", div_kind, 2'b11);
    cmp_data_en = 1'b0;

    // ---------------- 4a: mismatch only during ARM ----------------
    set_same();
    lb_valid2 = 1'b0;
    go_watch();
    set_same();
    for (int i = 0; i <= 12; i++) step();
    chk("t4_arm_done", done, 1);
    chk("t4_arm_div", diverge, 0);

    // ---------------- 4b: mismatch only at final index 12 ----------------
    go_watch();
    for (int i = 0; i <= 12; i++) begin
      set_same();
      if (i == 12) lb_valid1 = 1'b0;
      step();
      if (i == 11) chk("t4_last_pre", {diverge, done}, 2'b00);
    end
    chk("t4_last_same_edge", {diverge, done}, 2'b11);
    chk("t4_last_cycle", div_cycle, 12);
    chk("t4_last_kind", div_kind, 2'b01);

    // ---------------- 5: start ignored in WATCH, reset mid-run -------------
    set_same();
    go_watch();
    for (int i = 0; i <= 6; i++) begin
      set_same();
      if (i == 2) lb_valid2 = 1'b0;
      if (i == 4) start = 1'b1;
      step();
      start = 1'b0;
      if (i == 4) begin
        chk("t5_start_ignored_cnt", watch_cnt, 5);
        chk("t5_start_ignored_div", {busy, diverge}, 2'b11);
        chk("t5_start_ignored_cyc", div_cycle, 2);
      end
    end
    set_same();
    chk("t5_at_idx7", watch_cnt, 7);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_flags", {busy, done, diverge, div_kind}, 5'b0);
    chk("t5_rst_cnts", {watch_cnt, div_cycle}, 16'h0);
    chk("t5_rst_addrs", {div_addr1, div_addr2}, 64'h0);
    step();
    rst = 1'b0;
    step();
    step();
    step();
    chk("t5_needs_start", {busy, done}, 2'b00);

    // ---------------- 6: ARM_DELAY=0, WINDOW=0 ----------------
    set_same();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t6_cycle1", {busy0, done0}, 2'b10);
    chk("t6_cycle1_cnt", watch_cnt0, 0);
    step();
    chk("t6_cycle2", {busy0, done0, diverge0}, 3'b010);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    lb_valid2 = 1'b0;
    step();
    chk("t6_mm_same_edge", {done0, diverge0}, 2'b11);
    chk("t6_mm_kind_cycle", {div_kind0, div_cycle0}, {2'b01, 8'd0});
    set_same();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
